// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked RV32 data-memory responder with sub-word RMW; optional DMEM_MISALIGN_TRAP_EN
module dmem_responder #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_mask_type,
    input  logic        req_ext_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    // Word-wide single-port array, synchronous read, no byte enables.
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mem_rdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;

    // Request fields captured on accept; live inputs are ignored afterwards.
    logic [IDX_W-1:0] q_idx;
    logic [1:0]       q_lane;
    logic             q_we;
    logic             q_word;
    logic             q_half;
    logic             q_ext;
    logic [31:0]      q_wdata;

    // Incoming request decode.
    logic       req_fire;
    logic       in_word;
    logic       in_half;
    logic [1:0] in_lane;
    logic       misalign_in;
    logic       unused_addr_hi;

    // Lane datapath.
    logic [4:0]  lane_shift;
    logic [31:0] lane_data;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;
    logic [31:0] wdata_shifted;

    assign req_ready = (state == S_IDLE) && !rst;
    assign req_fire  = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);

    // Address bits above the array index wrap silently.
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign in_word = req_mask_type[1];
    assign in_half = (req_mask_type == 2'b01);

    // Lane selection forces misaligned low bits to zero; with trapping on,
    // misaligned requests never reach the array so the forcing is harmless.
    assign in_lane = in_word ? 2'b00 :
                     in_half ? {req_addr[1], 1'b0} :
                               req_addr[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    assign misalign_in = (in_half && req_addr[0]) ||
                         (in_word && (req_addr[1:0] != 2'b00));
    assign rsp_err     = err_q;

    // Error flag is decided at accept and held through the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (req_fire) begin
            err_q <= misalign_in;
        end
    end
`else
    assign misalign_in = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // Capture the request on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_idx   <= '0;
            q_lane  <= 2'b00;
            q_we    <= 1'b0;
            q_word  <= 1'b0;
            q_half  <= 1'b0;
            q_ext   <= 1'b0;
            q_wdata <= 32'h0;
        end else if (req_fire) begin
            q_idx   <= req_addr[IDX_W+1:2];
            q_lane  <= in_lane;
            q_we    <= req_we;
            q_word  <= in_word;
            q_half  <= in_half;
            q_ext   <= req_ext_type;
            q_wdata <= req_wdata;
        end
    end

    // Lane extraction with load extension, and sub-word merge for RMW stores.
    always_comb begin
        lane_shift    = {q_lane, 3'b000};
        lane_data     = mem_rdata >> lane_shift;
        byte_mask     = 32'h0000_00FF << lane_shift;
        half_mask     = 32'h0000_FFFF << lane_shift;
        wdata_shifted = q_wdata << lane_shift;
        load_value    = mem_rdata;
        merged_word   = mem_rdata;
        if (q_word) begin
            load_value  = mem_rdata;
            merged_word = q_wdata;
        end else if (q_half) begin
            load_value  = q_ext ? {16'h0000, lane_data[15:0]}
                                : {{16{lane_data[15]}}, lane_data[15:0]};
            merged_word = (mem_rdata & ~half_mask) | (wdata_shifted & half_mask);
        end else begin
            load_value  = q_ext ? {24'h000000, lane_data[7:0]}
                                : {{24{lane_data[7]}}, lane_data[7:0]};
            merged_word = (mem_rdata & ~byte_mask) | (wdata_shifted & byte_mask);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and array control; reset blocks any pending array write.
    always_comb begin
        state_n   = state;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = q_wdata;
        case (state)
            S_IDLE: begin
                if (req_fire) begin
                    state_n = misalign_in ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (q_we && q_word) begin
                    mem_we  = 1'b1;
                    state_n = S_RESP;
                end else begin
                    mem_re  = 1'b1;
                    state_n = S_MERGE;
                end
            end
            S_MERGE: begin
                if (q_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = merged_word;
                end
                state_n = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Array port: contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[q_idx] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata <= mem[q_idx];
        end
    end

    // Response data: cleared on accept, loaded in MERGE for loads, held in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= 32'h0;
        end else if (req_fire) begin
            rsp_rdata <= 32'h0;
        end else if ((state == S_MERGE) && !q_we) begin
            rsp_rdata <= load_value;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a byte-level memory model
module tb_dmem_responder;

    localparam int D  = 64;
    localparam int AW = 4 * D;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_mask_type;
    logic        req_ext_type;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int ncmp  = 0;
    int nfail = 0;

    logic [7:0] bmem [AW];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(D)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_mask_type(req_mask_type),
        .req_ext_type(req_ext_type),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, accesses as little-endian byte groups.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic ext,
                         output logic [31:0] rd, output logic err, output int lat);
        int n;
        int a;
        logic [31:0] v;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a   = int'(addr % 32'(AW));
        rd  = 32'h0;
        err = 1'b0;
        lat = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((a % n) != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`endif
        a = a - (a % n);
        if (we) begin
            for (int i = 0; i < n; i++) bmem[a + i] = wdata[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[a + i];
            if (n < 4 && !ext && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            rd  = v;
            lat = 3;
        end
    endtask

    // One complete transaction; optional response backpressure and junk request during busy.
    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic ext,
                       input int hold, input bit junk, output logic [31:0] obs_rd);
        logic [31:0] erd;
        logic        eerr;
        int          elat;
        int          lat;
        logic [31:0] held;
        model(we, addr, wdata, size, ext, erd, eerr, elat);
        chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid     = 1'b1;
        req_we        = we;
        req_addr      = addr;
        req_wdata     = wdata;
        req_mask_type = size;
        req_ext_type  = ext;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (junk) begin
            req_valid     = 1'b1;
            req_we        = 1'b1;
            req_addr      = $urandom;
            req_wdata     = $urandom;
            req_mask_type = 2'($urandom_range(0, 3));
        end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " rdata"}, rsp_rdata, erd);
        chk({tag, " err"}, 32'(rsp_err), 32'(eerr));
        obs_rd = rsp_rdata;
        held   = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold_rdata"}, rsp_rdata, held);
            chk({tag, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, " back_idle"}, 32'(req_ready), 32'd1);
        chk({tag, " valid_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        req_mask_type = 2'd0;
        req_ext_type  = 1'b0;
        rsp_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        #1;

        // Fill the whole array so every later load has defined data.
        for (int w = 0; w < D; w++) run("init", 1'b1, 32'(4 * w), $urandom, 2'd2, 1'b0, 0, 1'b0, r);

        run("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, r);
        run("lw_10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1'b0, r);
        chk("lw_10 const", r, 32'hDEADBEEF);

        run("sw_20", 1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 0, 1'b0, r);
        run("sb_22", 1'b1, 32'h22, 32'h000000AB, 2'd0, 1'b0, 0, 1'b0, r);
        run("lw_20", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 1'b0, r);
        chk("rmw const", r, 32'h11AB3344);

        run("sw_30", 1'b1, 32'h30, 32'h80FF7F01, 2'd2, 1'b0, 0, 1'b0, r);
        run("lb_33", 1'b0, 32'h33, 32'h0, 2'd0, 1'b0, 0, 1'b0, r);
        chk("lb const", r, 32'hFFFFFF80);
        run("lbu_33", 1'b0, 32'h33, 32'h0, 2'd0, 1'b1, 0, 1'b0, r);
        chk("lbu const", r, 32'h00000080);
        run("lh_30", 1'b0, 32'h30, 32'h0, 2'd1, 1'b0, 0, 1'b0, r);
        chk("lh const", r, 32'h00007F01);
        run("lhu_32", 1'b0, 32'h32, 32'h0, 2'd1, 1'b1, 0, 1'b0, r);
        chk("lhu const", r, 32'h000080FF);

        run("lw_wrap", 1'b0, 32'h10 + 32'(AW), 32'h0, 2'd2, 1'b0, 5, 1'b1, r);
        chk("wrap const", r, 32'hDEADBEEF);

        run("lw_13", 1'b0, 32'h13, 32'h0, 2'd2, 1'b0, 0, 1'b0, r);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalign const", r, 32'h0);
`else
        chk("misalign const", r, 32'hDEADBEEF);
`endif

        // Reset while a halfword RMW sits in MERGE: write must be dropped.
        run("sw_40", 1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0, 0, 1'b0, r);
        req_valid     = 1'b1;
        req_we        = 1'b1;
        req_addr      = 32'h40;
        req_wdata     = 32'h0000BEEF;
        req_mask_type = 2'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rmw no_rsp", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        run("lw_40", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, 1'b0, r);
        chk("rst_rmw const", r, 32'h12345678);

        for (int k = 0; k < 150; k++) begin
            run("rand", 1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the RISC-V core's load/store path. It accepts one load or store request at a time on a valid/ready request channel and performs the access on an internal single-port, synchronous-read, word-wide array. The array has no byte enables, so byte and halfword stores are done as read-modify-write. Results return on a valid/ready response channel with RV32I load extension applied. It is the memory-side counterpart of the core's load/store issue logic and replaces the combinational data memory when the core runs with a handshaked memory.

## Interface
- `DEPTH_WORDS`, default 1024: array depth in 32-bit words; must be a power of two ≥ 4.
- `IDX_W`, default `$clog2(DEPTH_WORDS)`: word-index width; derived, not overridden.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request; high only in IDLE and not in reset.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the sub-word value is taken from the low bits.
- `req_mask_type` input 2: access size. 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `req_ext_type` input 1: load extension. 0 = sign-extend (LB/LH), 1 = zero-extend (LBU/LHU); ignored for word accesses and stores.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_rdata` output 32: extended load data; 0 for stores and error responses.
- `rsp_err` output 1: misaligned-access error (see Configuration).

## Operation
- Request handshake: a request transfers on a cycle with `req_valid && req_ready`. All request fields are latched on that cycle and the live inputs are ignored afterwards.
- Word index is `addr[IDX_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- Byte lane is `addr[1:0]` for byte accesses. Halfword lane is `addr[1]`.
- State machine:
  - IDLE (`req_ready`=1).
    - On accept of a misaligned request while trapping is enabled: go to RESP with `rsp_err`=1.
    - On any other accept: go to ACCESS.
  - ACCESS: array addressed with the latched index.
    - Word store: write `req_wdata` this cycle, then go to RESP.
    - Load or sub-word store: issue the array read, then go to MERGE.
  - MERGE: array read data is valid.
    - Load: select the lane, extend it to 32 bits, and register the result into `rsp_rdata`.
    - Sub-word store: replace only the addressed byte or half of the read word with the `req_wdata` low bits, and write the merged word back.
    - Then go to RESP.
  - RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` stay stable until `rsp_ready` is sampled high. On that edge go to IDLE.
- A store followed by a load to the same word returns the stored value, because the write commits before RESP.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset values: state = IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `req_ready`=0 while `rst` is high.
- Latency is counted from the accept edge T to `rsp_valid` rising:
  - Word store: T+2.
  - Load: T+3.
  - Sub-word store: T+3.
  - Trapped misaligned access: T+1.
- Throughput: one request in flight. `req_ready` returns on the cycle after the response handshake, so back-to-back accesses take at least 3 or 4 cycles each.
- `rsp_ready` held high in RESP gives a single-cycle response.
- Reset mid-operation:
  - Reset in ACCESS or MERGE suppresses any pending array write.
  - The in-flight request is dropped and no response is produced.
  - The state returns to IDLE on the next edge.
- `req_valid` asserted outside IDLE is not accepted and has no effect.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - It produces an error response (`rsp_err`=1, `rsp_rdata`=0) one cycle after accept.
  - The array is not read or written.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - Misaligned low address bits are forced to zero: `addr[0]` for half, `addr[1:0]` for word.
  - The access proceeds normally, and `rsp_err` is tied to 0.

## Test plan
- Word store then load: SW 0xDEADBEEF to 0x10, then LW 0x10. Expect store `rsp_valid` at T+2, load `rsp_rdata`=0xDEADBEEF at T+3, `rsp_err`=0.
- Byte read-modify-write: with word 0x11223344 at 0x20, SB 0xAB to 0x22, then LW 0x20. Expect 0x11AB3344, with the store response at T+3.
- Load extension: with word 0x80FF7F01 at 0x30:
  - LB 0x33 returns 0xFFFFFF80.
  - LBU 0x33 returns 0x00000080.
  - LH 0x30 returns 0x00007F01.
  - LHU 0x32 returns 0x000080FF.
- Backpressure and wrap: LW to 0x10 + 4*DEPTH_WORDS with `rsp_ready` low for 5 cycles. Expect data from 0x10 held stable, `req_ready`=0 throughout, IDLE on the cycle after `rsp_ready`=1.
- Misaligned, with the macro defined: LW 0x13 returns `rsp_err`=1 at T+1 with no array access. Without the macro, the same LW returns the word at 0x10.
- Reset mid-RMW: SH 0xBEEF to 0x40 over 0x12345678, with `rst` asserted in MERGE. Expect no response, `rsp_valid`=0, and a subsequent LW 0x40 returning 0x12345678.
